duty_ramp_gen: RTL and testbench

- Upstream stage of the PWM duty-cycle divider: generates the 8-bit duty word that the divider compares against its free-running count.
- Produces a repeating breathing profile: ramp up to a programmable ceiling, hold, ramp down to zero, hold, repeat.
- Step rate comes from an internal prescaler, so LED fades are visible at the board clock.

---
 rtl/duty_pkg.sv | 14 +
 rtl/step_prescaler.sv | 39 +++
 rtl/duty_ramp_gen.sv | 132 +++++++++++++
 tb/tb_duty_ramp_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/duty_pkg.sv
// rtl/duty_pkg.sv - shared types and defaults for the duty ramp generator
package duty_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } ramp_state_t;

    localparam int unsigned DUTY_W_DEF = 8;

endpackage

// File: rtl/step_prescaler.sv
// rtl/step_prescaler.sv - free-running step prescaler with enable and synchronous clear
module step_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/duty_ramp_gen.sv
// rtl/duty_ramp_gen.sv - breathing duty-word generator feeding the PWM divider
module duty_ramp_gen
    import duty_pkg::*;
#(
    parameter int unsigned STEP_DIV   = 390625,
    parameter int unsigned HOLD_STEPS = 64,
    parameter int unsigned DUTY_W     = DUTY_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DUTY_W-1:0] max_duty,
    input  logic [3:0]        step_size,
    output logic [DUTY_W-1:0] duty,
    output logic              step_tick,
    output logic              rising
);

    localparam int unsigned HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);

    ramp_state_t       state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [HW-1:0]     hold_q, hold_d;

    logic [3:0]        step_eff;
    logic [DUTY_W:0]   sum;
    logic [DUTY_W-1:0] step_n;
    logic              over_ceiling;

    step_prescaler #(
        .DIV (STEP_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (state_q == IDLE),
        .tick  (step_tick)
    );

    // Widened sum keeps the top step from wrapping past the ceiling.
    assign step_eff     = (step_size == 4'd0) ? 4'd1 : step_size;
    assign step_n       = DUTY_W'(step_eff);
    assign sum          = {1'b0, duty_q} + {1'b0, step_n};
    assign over_ceiling = (duty_q > max_duty);

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        if (!en) begin
            state_d = IDLE;
            duty_d  = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RISE;
                    duty_d  = '0;
                    hold_d  = '0;
                end
                RISE: begin
                    if (over_ceiling || (step_tick && (sum >= {1'b0, max_duty}))) begin
                        duty_d  = max_duty;
                        state_d = HOLD_HI;
                        hold_d  = '0;
                    end else if (step_tick) begin
                        duty_d = sum[DUTY_W-1:0];
                    end
                end
                HOLD_HI: begin
                    if (over_ceiling) begin
                        duty_d = max_duty;
                    end
                    if (step_tick) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = FALL;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + HW'(1);
                        end
                    end
                end
                FALL: begin
                    // A lowered ceiling wins over a coincident step; descent resumes next tick.
                    if (over_ceiling) begin
                        duty_d = max_duty;
                    end else if (step_tick) begin
                        if (duty_q <= step_n) begin
                            duty_d  = '0;
                            state_d = HOLD_LO;
                            hold_d  = '0;
                        end else begin
                            duty_d = duty_q - step_n;
                        end
                    end
                end
                HOLD_LO: begin
                    if (step_tick) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = RISE;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + HW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    duty_d  = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            duty_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
        end
    end

    assign duty   = duty_q;
    assign rising = (state_q == RISE) || (state_q == HOLD_HI);

endmodule

// File: tb/tb_duty_ramp_gen.sv
// tb/tb_duty_ramp_gen.sv - randomized scoreboard bench for duty_ramp_gen
module tb_duty_ramp_gen;

    localparam int DIV  = 4;
    localparam int HOLD = 2;

    localparam int P_IDLE = 0;
    localparam int P_RISE = 1;
    localparam int P_HHI  = 2;
    localparam int P_FALL = 3;
    localparam int P_HLO  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] max_duty = 8'd0;
    logic [3:0] step_size = 4'd0;
    logic [7:0] duty;
    logic       step_tick;
    logic       rising;

    duty_ramp_gen #(
        .STEP_DIV   (DIV),
        .HOLD_STEPS (HOLD),
        .DUTY_W     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .max_duty  (max_duty),
        .step_size (step_size),
        .duty      (duty),
        .step_tick (step_tick),
        .rising    (rising)
    );

    always #5 clk = ~clk;

    typedef struct {
        int duty;
        int tick;
        int rising;
    } exp_t;

    exp_t exp_q[$];
    int   tick_log[$];
    bit   log_en  = 1'b0;
    bit   started = 1'b0;
    bit   prev_tick = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: phase, duty level, cycle within the step period, hold ticks remaining.
    int m_phase, m_duty, m_cyc, m_left;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_duty  = 0;
        m_cyc   = 0;
        m_left  = 0;
    endtask

    task automatic model_step(input bit e, input int mx, input int ss);
        bit tk;
        int s;
        tk = (m_cyc == DIV - 1);
        s  = (ss == 0) ? 1 : ss;
        if (!e) begin
            model_reset();
            return;
        end
        m_cyc = (m_phase == P_IDLE || tk) ? 0 : m_cyc + 1;
        case (m_phase)
            P_IDLE: m_phase = P_RISE;
            P_RISE: begin
                if (m_duty > mx || (tk && m_duty + s >= mx)) begin
                    m_duty  = mx;
                    m_phase = P_HHI;
                    m_left  = HOLD;
                end else if (tk) begin
                    m_duty = m_duty + s;
                end
            end
            P_HHI: begin
                if (m_duty > mx) m_duty = mx;
                if (tk) begin
                    m_left--;
                    if (m_left == 0) m_phase = P_FALL;
                end
            end
            P_FALL: begin
                if (m_duty > mx) begin
                    m_duty = mx;
                end else if (tk) begin
                    if (m_duty <= s) begin
                        m_duty  = 0;
                        m_phase = P_HLO;
                        m_left  = HOLD;
                    end else begin
                        m_duty = m_duty - s;
                    end
                end
            end
            default: begin
                if (tk) begin
                    m_left--;
                    if (m_left == 0) m_phase = P_RISE;
                end
            end
        endcase
    endtask

    task automatic drive(input bit r, input bit e, input int mx, input int ss);
        exp_t x;
        @(negedge clk);
        rst_n     = r;
        en        = e;
        max_duty  = mx[7:0];
        step_size = ss[3:0];
        if (!r) model_reset();
        else    model_step(e, mx, ss);
        x.duty   = m_duty;
        x.tick   = (m_cyc == DIV - 1) ? 1 : 0;
        x.rising = (m_phase == P_RISE || m_phase == P_HHI) ? 1 : 0;
        exp_q.push_back(x);
        started = 1'b1;
    endtask

    task automatic run(input int n, input bit e, input int mx, input int ss);
        for (int i = 0; i < n; i++) drive(1'b1, e, mx, ss);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 10, 4);
    endtask

    task automatic check_log(input string nm, input int exp[$]);
        chk({nm, "_count"}, (tick_log.size() >= exp.size()) ? 1 : 0, 1);
        foreach (exp[i]) begin
            if (i < tick_log.size()) chk($sformatf("%s_tick%0d", nm, i), tick_log[i], exp[i]);
        end
    endtask

    // Monitor: every cycle the DUT presents a registered output set; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                if (started) chk("scoreboard_underflow", 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk("duty", duty, e.duty);
                chk("step_tick", step_tick, e.tick);
                chk("rising", rising, e.rising);
            end
            if (log_en && prev_tick) tick_log.push_back(int'(duty));
            prev_tick = step_tick;
        end
    end

    initial begin
        int exp_l[$];
        int mx, ss;
        bit e;
        model_reset();

        do_reset();
        @(posedge clk); #1;
        chk("reset_duty", duty, 0);
        chk("reset_tick", step_tick, 0);
        chk("reset_rising", rising, 0);

        // Full breathing cycle.
        tick_log.delete();
        log_en = 1'b1;
        run(50, 1'b1, 10, 4);
        log_en = 1'b0;
        exp_l = '{4, 8, 10, 10, 10, 6, 2, 0, 0, 0, 4};
        check_log("full_cycle", exp_l);

        // step_size 0 behaves as 1.
        do_reset();
        tick_log.delete();
        log_en = 1'b1;
        run(40, 1'b1, 3, 0);
        log_en = 1'b0;
        exp_l = '{1, 2, 3, 3, 3, 2, 1, 0};
        check_log("step_zero", exp_l);

        // Lowered ceiling during RISE.
        do_reset();
        for (int i = 0; i < 200 && !(m_phase == P_RISE && m_duty == 200); i++) drive(1'b1, 1'b1, 255, 10);
        chk("reach_200", (m_phase == P_RISE && m_duty == 200) ? 1 : 0, 1);
        drive(1'b1, 1'b1, 100, 10);
        @(posedge clk); #1;
        chk("clamp_duty", duty, 100);
        chk("clamp_rising", rising, 1);
        run(20, 1'b1, 100, 10);

        // Top step saturates at 255.
        do_reset();
        for (int i = 0; i < 200 && !(m_phase == P_RISE && m_duty == 250); i++) drive(1'b1, 1'b1, 255, 10);
        chk("reach_250", (m_phase == P_RISE && m_duty == 250) ? 1 : 0, 1);
        for (int i = 0; i < 10 && m_phase == P_RISE; i++) drive(1'b1, 1'b1, 255, 15);
        @(posedge clk); #1;
        chk("overflow_duty", duty, 255);

        // Enable drop coincident with a tick in FALL at 50.
        do_reset();
        for (int i = 0; i < 300 && !(m_phase == P_FALL && m_duty == 50 && m_cyc == DIV - 1); i++)
            drive(1'b1, 1'b1, 60, 10);
        chk("reach_fall50", (m_phase == P_FALL && m_duty == 50 && m_cyc == DIV - 1) ? 1 : 0, 1);
        drive(1'b1, 1'b0, 60, 10);
        @(posedge clk); #1;
        chk("endrop_duty", duty, 0);
        chk("endrop_rising", rising, 0);
        tick_log.delete();
        log_en = 1'b1;
        run(6, 1'b1, 60, 10);
        log_en = 1'b0;
        exp_l = '{10};
        check_log("reenable", exp_l);

        // Randomized traffic.
        mx = 128; ss = 5; e = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) mx = $urandom_range(0, 255);
            if ($urandom_range(0, 29) == 0) ss = $urandom_range(0, 15);
            if ($urandom_range(0, 99) == 0) e = ~e;
            if ($urandom_range(0, 799) == 0) drive(1'b0, e, mx, ss);
            else                             drive(1'b1, e, mx, ss);
        end

        @(posedge clk); #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
